// File: rtl/dds_pkg.sv
// Purpose: shared defaults, state encoding and phase constants for the DDS phase accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int ADDRW_DEF = 8;
  localparam int DIV_W_DEF = 8;

  // 90 degrees of phase at the default accumulator width (2^(ACC_W-2)).
  localparam logic [ACC_W_DEF-1:0] QUARTER_PHASE = {2'b01, {(ACC_W_DEF-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Purpose: sample-rate divider; raises tick once every count+1 enabled cycles.
// Latency: tick is combinational from the internal counter.
// Backpressure: freeze holds the counter (and a pending tick) until released.
//
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   count    : terminal count; tick when the counter reaches it (0 = every cycle)
//   clear    : force the counter back to 0 (phase sync)
//   freeze   : hold the counter, e.g. while the output slot is blocked
//   tick     : sample strobe
module tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] count,
  input  logic             clear,
  input  logic             freeze,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so a counter left above a freshly lowered
  // terminal count still wraps on the next cycle instead of running to 2^DIV_W.
  assign tick = (cnt_q >= count);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dds_phase_acc.sv
// Purpose: DDS phase accumulator producing sine-table indices with a shadowed config.
// Latency: 1 cycle from divider tick to id_valid.
// Backpressure: id_ready low on a tick parks the tick (HOLD); acc and divider freeze, no sample lost.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   en                : run enable; low stops new samples, phase retained
//   sync              : one-cycle clear of acc, divider and the output slot
//   cfg_valid/ready   : config handshake for cfg_ftw, cfg_phase, cfg_div
//   id_valid/ready    : output handshake for id (table index) and wrap (acc overflow)
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [ACC_W-1:0] cfg_phase,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [ADDRW-1:0] id,
  output logic             wrap
);

  state_t           state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] ftw_q;
  logic [ACC_W-1:0] ofs_q;
  logic [DIV_W-1:0] div_q;

  logic [ACC_W-1:0] sh_ftw_q;
  logic [ACC_W-1:0] sh_ofs_q;
  logic [DIV_W-1:0] sh_div_q;
  logic             pend_q;

  logic [ADDRW-1:0] id_q;
  logic             id_valid_q;
  logic             wrap_q;

  logic             tick;
  logic             active;
  logic             slot_free;
  logic             stall;
  logic             fire;
  logic             div_freeze;
  logic             activate;
  logic             cfg_xfer;
  logic [ACC_W:0]   acc_step;
  logic [ACC_W-1:0] phase_sum;

  assign active    = (state_q != ST_IDLE);
  assign slot_free = !id_valid_q || id_ready;
  assign stall     = tick && !slot_free;
  // sync wins over a coincident tick: the cleared phase must not be overwritten.
  assign fire      = active && en && tick && slot_free && !sync;
  // Freezing on a stalled tick keeps the tick asserted, so the parked sample
  // is issued exactly once as soon as the slot frees up.
  assign div_freeze = !active || !en || stall;

  // A shadow is pending while cfg_ready is low; it lands on a sample tick
  // (after that sample used the old values) or immediately when idle.
  assign cfg_ready = !pend_q;
  assign cfg_xfer  = cfg_valid && !pend_q;
  assign activate  = pend_q && (fire || (state_q == ST_IDLE));

  assign acc_step  = {1'b0, acc_q} + {1'b0, ftw_q};
  assign phase_sum = acc_q + ofs_q;  // modulo add, carry intentionally dropped

  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .count  (div_q),
    .clear  (sync),
    .freeze (div_freeze),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          if (slot_free) state_d = ST_IDLE;
        end else if (stall) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (id_ready) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    // sync empties the slot, so nothing is left to wait for.
    if (sync) state_d = en ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ftw_q      <= '0;
      ofs_q      <= '0;
      div_q      <= '0;
      sh_ftw_q   <= '0;
      sh_ofs_q   <= '0;
      sh_div_q   <= '0;
      pend_q     <= 1'b0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (cfg_xfer) begin
        sh_ftw_q <= cfg_ftw;
        sh_ofs_q <= cfg_phase;
        sh_div_q <= cfg_div;
        pend_q   <= 1'b1;
      end else if (activate) begin
        ftw_q  <= sh_ftw_q;
        ofs_q  <= sh_ofs_q;
        div_q  <= sh_div_q;
        pend_q <= 1'b0;
      end

      if (sync) begin
        acc_q      <= '0;
        id_valid_q <= 1'b0;
      end else if (fire) begin
        id_q       <= phase_sum[ACC_W-1 -: ADDRW];
        acc_q      <= acc_step[ACC_W-1:0];
        wrap_q     <= acc_step[ACC_W];
        id_valid_q <= 1'b1;
      end else if (id_ready) begin
        id_valid_q <= 1'b0;
      end
    end
  end

  // Index goes straight to the sine table address port.
  assign id       = id_q;
  assign id_valid = id_valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Purpose: directed self-checking bench for dds_phase_acc.
// Latency: n/a.
// Backpressure: exercised via id_ready stalls.
module tb_dds_phase_acc;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_ftw;
  logic [15:0] cfg_phase;
  logic [7:0]  cfg_div;
  logic        id_valid;
  logic        id_ready;
  logic [7:0]  id;
  logic        wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_phase_acc #(
    .ACC_W (16),
    .ADDRW (8),
    .DIV_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_phase (cfg_phase),
    .cfg_div   (cfg_div),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id        (id),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (id_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(id_valid), 32'd1);
  endtask

  task automatic load_cfg(input logic [15:0] f, input logic [15:0] p, input logic [7:0] d);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ftw   = f;
    cfg_phase = p;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;

    rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_phase = '0; cfg_div = '0; id_ready = 1'b1;
    step();
    step();
    check("rst_id_valid",  32'(id_valid),  32'd0);
    check("rst_id",        32'(id),        32'd0);
    check("rst_wrap",      32'(wrap),      32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    step();
    check("idle_no_sample", 32'(id_valid), 32'd0);

    // ftw 0x0100, div 0: one index per cycle, full sweep plus wrap
    load_cfg(16'h0100, 16'h0000, 8'd0);
    check("cfg_ready_drop", 32'(cfg_ready), 32'd0);
    step();
    check("cfg_ready_return", 32'(cfg_ready), 32'd1);
    check("idle_still_empty", 32'(id_valid), 32'd0);
    en = 1'b1;
    wait_valid("sweep_first_valid", 10, n);
    check("sweep_start_latency", 32'(n), 32'd2);
    for (int k = 0; k <= 256; k++) begin
      check("sweep_valid", 32'(id_valid), 32'd1);
      check("sweep_id",    32'(id),       32'(k % 256));
      check("sweep_wrap",  32'(wrap),     (k == 255) ? 32'd1 : 32'd0);
      step();
    end

    // sync mid-run: slot empties, then restart from 0
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clears_valid", 32'(id_valid), 32'd0);
    step();
    check("sync_restart_valid", 32'(id_valid), 32'd1);
    check("sync_restart_id",    32'(id),       32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("pre_hold_id", 32'(id), 32'(k));
    end

    // backpressure at id 10 for 5 cycles
    id_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      step();
      check("hold_id",    32'(id),       32'd10);
      check("hold_valid", 32'(id_valid), 32'd1);
    end
    id_ready = 1'b1;
    step();
    check("after_hold_id_11", 32'(id), 32'd11);
    step();
    check("after_hold_id_12", 32'(id), 32'd12);

    // rst mid-run beats sync, en and a config offer
    rst = 1'b1; sync = 1'b1; cfg_valid = 1'b1;
    cfg_ftw = 16'h0300; cfg_div = 8'd5;
    step();
    check("rst_run_valid",     32'(id_valid),  32'd0);
    check("rst_run_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_run_id",        32'(id),        32'd0);
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; en = 1'b0;
    step();
    check("rst_shadow_discarded", 32'(cfg_ready), 32'd1);
    check("rst_idle_valid",       32'(id_valid),  32'd0);

    // div 3: one sample every 4 cycles, restart from id 0
    load_cfg(16'h0100, 16'h0000, 8'd3);
    step();
    en = 1'b1;
    wait_valid("div_first_valid", 20, n);
    check("div_id_0", 32'(id), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("div_valid_clears", 32'(id_valid), 32'd0);
      wait_valid("div_valid", 20, n);
      gap = n + 1;
      check("div_gap", 32'(gap), 32'd4);
      check("div_id",  32'(id),  32'(k));
    end

    // ftw change 0x0100 -> 0x0200 landing on the id 5 tick
    en = 1'b0;
    step(); step(); step();
    load_cfg(16'h0100, 16'h0000, 8'd0);
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    en = 1'b1;
    wait_valid("ftw_first_valid", 10, n);
    check("ftw_id_0", 32'(id), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("ftw_id_pre", 32'(id), 32'(k));
    end
    cfg_valid = 1'b1; cfg_ftw = 16'h0200; cfg_phase = 16'h0000; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    check("ftw_id_4",        32'(id),        32'd4);
    check("ftw_cfg_pending", 32'(cfg_ready), 32'd0);
    step();
    check("ftw_id_5",         32'(id),        32'd5);
    check("ftw_cfg_released", 32'(cfg_ready), 32'd1);
    step();
    check("ftw_id_6", 32'(id), 32'd6);
    step();
    check("ftw_id_8", 32'(id), 32'd8);
    step();
    check("ftw_id_10", 32'(id), 32'd10);

    // quarter-phase offset with ftw 0: constant index 64, never wraps
    en = 1'b0;
    step(); step(); step();
    load_cfg(16'h0000, QUARTER_PHASE, 8'd0);
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    en = 1'b1;
    wait_valid("ofs_first_valid", 10, n);
    for (int i = 0; i < 4; i++) begin
      check("ofs_id",   32'(id),   32'd64);
      check("ofs_wrap", 32'(wrap), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_phase_acc.md
DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

Interface
REQ-001 Parameter ACC_W, default 16, SHALL set the phase accumulator width in bits.
REQ-002 Parameter ADDRW, default 8, SHALL set the output table-index width and SHALL equal the downstream sine table index width (4*ROM_DEPTH entries).
REQ-003 Parameter DIV_W, default 8, SHALL set the sample-rate divider width.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable; 0 = no new samples, phase retained.
REQ-007 sync  input  1  single-cycle phase clear.
REQ-008 cfg_valid  input  1  config offer.
REQ-009 cfg_ready  output  1  config slot free.
REQ-010 cfg_ftw  input  ACC_W  frequency tuning word.
REQ-011 cfg_phase  input  ACC_W  phase offset.
REQ-012 cfg_div  input  DIV_W  sample divider; one sample per cfg_div+1 cycles.
REQ-013 id_valid  output  1  id holds a sample.
REQ-014 id_ready  input  1  downstream accepts id.
REQ-015 id  output  ADDRW  table index = top ADDRW bits of (acc + phase offset).
REQ-016 wrap  output  1  sample flag: this step's accumulator addition overflowed.

Function
REQ-017 Config handshake: transfer SHALL occur on cfg_valid && cfg_ready; values SHALL go to a shadow register and cfg_ready SHALL drop the following cycle.
REQ-018 Shadow SHALL become active on the next tick, or in the next cycle when in IDLE; cfg_ready SHALL return to 1 the cycle after activation.
REQ-019 Tick: a divider counter SHALL count 0..div and SHALL tick when count == div; div = 0 SHALL tick every cycle.
REQ-020 States SHALL be IDLE, RUN and HOLD.
REQ-021 IDLE -> RUN SHALL occur on en = 1; RUN -> IDLE SHALL occur on en = 0 after any pending id is accepted.
REQ-022 RUN -> HOLD SHALL occur on a tick while id_valid && !id_ready; HOLD -> RUN SHALL occur on id_ready.
REQ-023 In HOLD, acc and the divider SHALL freeze and no sample SHALL be dropped or duplicated.
REQ-024 On a tick in RUN with the slot free (!id_valid || id_ready): id <= (acc + offset)[ACC_W-1 -: ADDRW]; acc <= acc + ftw mod 2^ACC_W; id_valid <= 1; wrap <= carry-out of acc + ftw.
REQ-025 Output latency SHALL be 1 cycle from tick to id_valid.
REQ-026 id_valid SHALL clear on acceptance when no new tick is present in the same cycle.
REQ-027 id and wrap SHALL stay stable while id_valid && !id_ready.
REQ-028 A config activated on a tick SHALL use the old ftw/offset for that tick's sample and the new values from the next tick.
REQ-029 sync SHALL clear acc, the divider and id_valid in the same cycle; it SHALL override a simultaneous tick and SHALL NOT affect the shadow config or cfg_ready.
REQ-030 Arithmetic SHALL be unsigned modulo 2^ACC_W; the offset addition SHALL NOT produce wrap.

Reset
REQ-031 rst SHALL set acc = 0, ftw = 0, offset = 0, div = 0, divider = 0, id = 0, id_valid = 0, wrap = 0, cfg_ready = 1 and state = IDLE.
REQ-032 rst asserted mid-operation SHALL discard the pending sample and shadow config, and SHALL take priority over sync, en and cfg.

Structure
REQ-033 Package dds_pkg SHALL hold the ACC_W/ADDRW/DIV_W defaults, the state encoding (IDLE/RUN/HOLD) and a QUARTER_PHASE constant (2^(ACC_W-2)).
REQ-034 The divider SHALL be sub-module tick_div (inputs: count, clear, freeze; output: tick).
REQ-035 The id output SHALL connect directly to the sine table index input.

Verification
REQ-036 Bench SHALL cover: ftw = 0x0100, div = 0, id_ready = 1 -> id 0,1,...,255,0 on consecutive cycles, wrap = 1 only with id = 255.
REQ-037 Bench SHALL cover: div = 3, ftw = 0x0100 -> one id per 4 cycles, id 0,1,2,...
REQ-038 Bench SHALL cover: id_ready low for 5 cycles at id = 10 -> id holds 10, next accepted id = 11, none skipped.
REQ-039 Bench SHALL cover: offset = 0x4000 (QUARTER_PHASE), ftw = 0 -> id constant 64.
REQ-040 Bench SHALL cover: ftw changed 0x0100 -> 0x0200 at id = 5 -> tick-sample 5 then 6, then 8, 10.
REQ-041 Bench SHALL cover: rst and sync pulsed mid-run -> id_valid = 0 next cycle, restart from id 0, cfg_ready = 1 after rst.
